// File: rtl/pe_pkg.sv
// Shared types and defaults for the PE operand sequencer.
package pe_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;

  typedef logic [31:0] vec_len_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STREAM,
    FINISH
  } seq_state_t;
endpackage

// File: rtl/vec_addr_gen.sv
// Per-vector read address register: loads base on start and advances on each issued read.
// With STRIDE_EN defined, the step is a stride latched on start; otherwise it is 1.
module vec_addr_gen
  import pe_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
`ifdef STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic [ADDR_W-1:0] addr
);
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] step;

`ifdef STRIDE_EN
  logic [ADDR_W-1:0] stride_q, stride_d;

  always_comb begin
    stride_d = stride_q;
    if (load) stride_d = stride;
  end

  always_ff @(posedge clk) begin
    if (rst) stride_q <= '0;
    else     stride_q <= stride_d;
  end

  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  // Addition wraps naturally at 2^ADDR_W.
  always_comb begin
    addr_d = addr_q;
    if (load)         addr_d = base;
    else if (advance) addr_d = addr_q + step;
  end

  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr = addr_q;
endmodule

// File: rtl/pe_operand_sequencer.sv
// Streams two operand vectors from synchronous-read memories into the PE and captures the dot product.
// Optional STRIDE_EN adds per-vector address strides latched on start.
module pe_operand_sequencer
  import pe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  vec_len_t          length,
  input  logic [ADDR_W-1:0] left_base,
  input  logic [ADDR_W-1:0] right_base,
`ifdef STRIDE_EN
  input  logic [ADDR_W-1:0] left_stride,
  input  logic [ADDR_W-1:0] right_stride,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dot_result,
  output logic              mem_en,
  output logic [ADDR_W-1:0] left_addr,
  output logic [ADDR_W-1:0] right_addr,
  input  logic [DATA_W-1:0] left_rdata,
  input  logic [DATA_W-1:0] right_rdata,
  output logic              pe_active,
  output logic              pe_vec_fin,
  output logic [DATA_W-1:0] pe_left,
  output logic [DATA_W-1:0] pe_right,
  input  logic              pe_step_fin,
  input  logic [DATA_W-1:0] pe_result
);
  seq_state_t        state_q, state_d;
  vec_len_t          len_q, len_d;
  vec_len_t          issue_q, issue_d;
  vec_len_t          acc_q, acc_d;
  logic [DATA_W-1:0] dot_q, dot_d;
  logic              zdone_q, zdone_d;
  logic              load, accept, last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (length != '0)) state_d = FETCH;
      FETCH:   state_d = STREAM;
      STREAM:  if (pe_step_fin && last) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy       = (state_q != IDLE);
    pe_active  = (state_q == STREAM);
    last       = (acc_q == (len_q - 32'd1));
    pe_vec_fin = pe_active && last;
    accept     = pe_active && pe_step_fin;
    // Stalls drop mem_en so the memories keep presenting the current operands.
    mem_en     = (state_q == FETCH) || (accept && (issue_q < len_q));
    load       = (state_q == IDLE) && start && (length != '0);
    done       = (state_q == FINISH) || zdone_q;
  end

  assign pe_left    = left_rdata;
  assign pe_right   = right_rdata;
  assign dot_result = dot_q;

  // Counters and result capture
  always_comb begin
    len_d   = len_q;
    issue_d = issue_q;
    acc_d   = acc_q;
    dot_d   = dot_q;
    zdone_d = (state_q == IDLE) && start && (length == '0);
    if (load) begin
      len_d   = length;
      issue_d = '0;
      acc_d   = '0;
    end
    if (mem_en) issue_d = issue_q + 32'd1;
    if (accept) begin
      acc_d = acc_q + 32'd1;
      if (last) dot_d = pe_result;
    end
    if (zdone_d) dot_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q   <= '0;
      issue_q <= '0;
      acc_q   <= '0;
      dot_q   <= '0;
      zdone_q <= 1'b0;
    end else begin
      len_q   <= len_d;
      issue_q <= issue_d;
      acc_q   <= acc_d;
      dot_q   <= dot_d;
      zdone_q <= zdone_d;
    end
  end

  vec_addr_gen #(.ADDR_W(ADDR_W)) u_left_ag (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (mem_en),
    .base    (left_base),
`ifdef STRIDE_EN
    .stride  (left_stride),
`endif
    .addr    (left_addr)
  );

  vec_addr_gen #(.ADDR_W(ADDR_W)) u_right_ag (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .advance (mem_en),
    .base    (right_base),
`ifdef STRIDE_EN
    .stride  (right_stride),
`endif
    .addr    (right_addr)
  );
endmodule

// File: tb/tb_pe_operand_sequencer.sv
// Directed bench for pe_operand_sequencer with behavioural memories and an accumulating PE.
module tb_pe_operand_sequencer;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
`ifdef STRIDE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic              clk = 1'b0;
  logic              rst, start, pe_step_fin;
  logic [31:0]       length;
  logic [ADDR_W-1:0] left_base, right_base;
`ifdef STRIDE_EN
  logic [ADDR_W-1:0] left_stride, right_stride;
`endif
  logic              busy, done, mem_en, pe_active, pe_vec_fin;
  logic [DATA_W-1:0] dot_result, left_rdata, right_rdata, pe_left, pe_right, pe_result;
  logic [ADDR_W-1:0] left_addr, right_addr;

  logic [DATA_W-1:0] left_mem  [1024];
  logic [DATA_W-1:0] right_mem [1024];
  logic [DATA_W-1:0] acc;

  int total = 0, passed = 0;

  always #5 clk = ~clk;

  pe_operand_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .left_base(left_base), .right_base(right_base),
`ifdef STRIDE_EN
    .left_stride(left_stride), .right_stride(right_stride),
`endif
    .busy(busy), .done(done), .dot_result(dot_result), .mem_en(mem_en),
    .left_addr(left_addr), .right_addr(right_addr),
    .left_rdata(left_rdata), .right_rdata(right_rdata),
    .pe_active(pe_active), .pe_vec_fin(pe_vec_fin),
    .pe_left(pe_left), .pe_right(pe_right),
    .pe_step_fin(pe_step_fin), .pe_result(pe_result)
  );

  // Synchronous single-port read memories
  always @(posedge clk) begin
    if (mem_en) begin
      left_rdata  <= left_mem[left_addr];
      right_rdata <= right_mem[right_addr];
    end
  end

  // PE: combinational accumulate, clears after the final element
  assign pe_result = acc + pe_left * pe_right;
  always @(posedge clk) begin
    if (rst) acc <= '0;
    else if (pe_active && pe_step_fin) acc <= pe_vec_fin ? '0 : pe_result;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance to a point just after the next rising edge; inputs set here apply to the next edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [31:0] len, input logic [ADDR_W-1:0] lb, input logic [ADDR_W-1:0] rb);
    start = 1'b1; length = len; left_base = lb; right_base = rb;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin left_mem[i] = '0; right_mem[i] = '0; end
    left_mem[0] = 1; left_mem[1] = 2; left_mem[2] = 3;
    right_mem[8] = 4; right_mem[9] = 5; right_mem[10] = 6;
    left_mem[1022] = 3; left_mem[1023] = 4;
    for (int i = 0; i < 4; i++) right_mem[i] = 1;
    left_rdata = '0; right_rdata = '0;
    rst = 1'b1; start = 1'b0; length = '0; left_base = '0; right_base = '0; pe_step_fin = 1'b1;
`ifdef STRIDE_EN
    left_stride = 1; right_stride = 1;
`endif

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_mem_en", mem_en, 0);
    chk("rst_active", pe_active, 0); chk("rst_vec_fin", pe_vec_fin, 0);
    chk("rst_dot", dot_result, 0); chk("rst_laddr", left_addr, 0); chk("rst_raddr", right_addr, 0);
    rst = 1'b0;

    // Basic length-3 dot product, no stalls
    cyc(); set_op(3, 0, 8); #1;
    chk("t1_c0_busy", busy, 0);
    cyc(); start = 1'b0; #1;
    chk("t1_c1_busy", busy, 1); chk("t1_c1_mem_en", mem_en, 1);
    chk("t1_c1_laddr", left_addr, 0); chk("t1_c1_raddr", right_addr, 8); chk("t1_c1_active", pe_active, 0);
    cyc(); #1;
    chk("t1_c2_active", pe_active, 1); chk("t1_c2_left", pe_left, 1); chk("t1_c2_right", pe_right, 4);
    chk("t1_c2_fin", pe_vec_fin, 0); chk("t1_c2_mem_en", mem_en, 1); chk("t1_c2_laddr", left_addr, 1);
    cyc(); #1;
    chk("t1_c3_left", pe_left, 2); chk("t1_c3_right", pe_right, 5); chk("t1_c3_fin", pe_vec_fin, 0);
    chk("t1_c3_laddr", left_addr, 2);
    cyc(); #1;
    chk("t1_c4_left", pe_left, 3); chk("t1_c4_fin", pe_vec_fin, 1); chk("t1_c4_mem_en", mem_en, 0);
    chk("t1_c4_result", pe_result, 32); chk("t1_c4_done", done, 0);
    cyc(); #1;
    chk("t1_c5_done", done, 1); chk("t1_c5_dot", dot_result, 32); chk("t1_c5_active", pe_active, 0);
    chk("t1_c5_busy", busy, 1);
    cyc(); #1;
    chk("t1_c6_done", done, 0); chk("t1_c6_busy", busy, 0);

    // Zero-length start
    cyc(); set_op(0, 5, 5); #1;
    chk("t3_c0_done", done, 0); chk("t3_c0_mem_en", mem_en, 0);
    cyc(); start = 1'b0; #1;
    chk("t3_c1_done", done, 1); chk("t3_c1_dot", dot_result, 0); chk("t3_c1_busy", busy, 0);
    chk("t3_c1_mem_en", mem_en, 0);
    cyc(); #1;
    chk("t3_c2_done", done, 0); chk("t3_c2_busy", busy, 0);

    // Two-cycle stall on the second element
    cyc(); set_op(3, 0, 8); #1;
    cyc(); start = 1'b0; #1;
    cyc(); #1;
    chk("t2_c2_left", pe_left, 1);
    cyc(); pe_step_fin = 1'b0; #1;
    chk("t2_c3_left", pe_left, 2); chk("t2_c3_right", pe_right, 5); chk("t2_c3_mem_en", mem_en, 0);
    chk("t2_c3_laddr", left_addr, 2);
    cyc(); #1;
    chk("t2_c4_left", pe_left, 2); chk("t2_c4_right", pe_right, 5); chk("t2_c4_laddr", left_addr, 2);
    chk("t2_c4_fin", pe_vec_fin, 0); chk("t2_c4_done", done, 0);
    cyc(); pe_step_fin = 1'b1; #1;
    chk("t2_c5_left", pe_left, 2); chk("t2_c5_mem_en", mem_en, 1); chk("t2_c5_laddr", left_addr, 2);
    cyc(); #1;
    chk("t2_c6_left", pe_left, 3); chk("t2_c6_fin", pe_vec_fin, 1); chk("t2_c6_result", pe_result, 32);
    chk("t2_c6_done", done, 0);
    cyc(); #1;
    chk("t2_c7_done", done, 1); chk("t2_c7_dot", dot_result, 32);

    // Left address wraps past 1023
    cyc(); set_op(4, 1022, 0); #1;
    cyc(); start = 1'b0; #1;
    chk("t4_c1_laddr", left_addr, 1022); chk("t4_c1_mem_en", mem_en, 1);
    cyc(); #1;
    chk("t4_c2_laddr", left_addr, 1023); chk("t4_c2_left", pe_left, 3);
    cyc(); #1;
    chk("t4_c3_laddr", left_addr, 0); chk("t4_c3_left", pe_left, 4);
    cyc(); #1;
    chk("t4_c4_laddr", left_addr, 1); chk("t4_c4_mem_en", mem_en, 1); chk("t4_c4_left", pe_left, 1);
    cyc(); #1;
    chk("t4_c5_left", pe_left, 2); chk("t4_c5_fin", pe_vec_fin, 1); chk("t4_c5_mem_en", mem_en, 0);
    cyc(); #1;
    chk("t4_c6_done", done, 1); chk("t4_c6_dot", dot_result, 10);

    // Reset mid-stream, then a clean length-2 run
    cyc(); set_op(3, 0, 8); #1;
    cyc(); start = 1'b0; #1;
    cyc(); #1;
    cyc(); rst = 1'b1; #1;
    chk("t5_c3_left", pe_left, 2);
    cyc(); rst = 1'b0; #1;
    chk("t5_busy", busy, 0); chk("t5_done", done, 0); chk("t5_mem_en", mem_en, 0);
    chk("t5_active", pe_active, 0); chk("t5_fin", pe_vec_fin, 0); chk("t5_dot", dot_result, 0);
    chk("t5_laddr", left_addr, 0); chk("t5_raddr", right_addr, 0);
    cyc(); #1;
    chk("t5_nodone", done, 0);
    cyc(); set_op(2, 0, 8); #1;
    cyc(); start = 1'b0; #1;
    cyc(); #1;
    chk("t5b_c2_left", pe_left, 1);
    cyc(); #1;
    chk("t5b_c3_fin", pe_vec_fin, 1); chk("t5b_c3_result", pe_result, 14);
    cyc(); #1;
    chk("t5b_c4_done", done, 1); chk("t5b_c4_dot", dot_result, 14);

    // Address step (stride 2 when enabled, otherwise 1)
`ifdef STRIDE_EN
    left_stride = 2; right_stride = 2;
`endif
    cyc(); set_op(3, 0, 8); #1;
    cyc(); start = 1'b0; #1;
    chk("t6_c1_laddr", left_addr, 0);
    cyc(); #1;
    chk("t6_c2_laddr", left_addr, STEP);
    cyc(); #1;
    chk("t6_c3_laddr", left_addr, 2 * STEP);
    cyc(); #1;
    chk("t6_c4_fin", pe_vec_fin, 1);
    cyc(); #1;
    chk("t6_c5_done", done, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pe_operand_sequencer.md
Name: pe_operand_sequencer

Overview:
- Upstream feeder for the processing element (PE) multiply-accumulate stage.
- On a start command, streams two operand vectors from a pair of synchronous single-port read memories into the PE, one element pair per accepted step.
- Drives the PE `active` and `vec_fin` controls, and captures the PE's final accumulated result as the dot product.
- Controller-facing side is a start/busy/done handshake.

Parameters:
- DATA_W, 32, operand and result width; matches PE datapath.
- ADDR_W, 10, memory address width; vector addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a vector operation; sampled only in IDLE
- length  in  32  element count; latched on accepted start
- left_base  in  ADDR_W  first address of left vector; latched on start
- right_base  in  ADDR_W  first address of right vector; latched on start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when dot_result is valid
- dot_result  out  DATA_W  registered final accumulation
- mem_en  out  1  read enable shared by both memories
- left_addr  out  ADDR_W  left memory read address
- right_addr  out  ADDR_W  right memory read address
- left_rdata  in  DATA_W  left read data, valid 1 cycle after an enabled address
- right_rdata  in  DATA_W  right read data, same timing as left_rdata
- pe_active  out  1  element pair valid on pe_left/pe_right
- pe_vec_fin  out  1  current element is the last of the vector
- pe_left  out  DATA_W  operand to PE left_in (= left_rdata)
- pe_right  out  DATA_W  operand to PE right_in (= right_rdata)
- pe_step_fin  in  1  PE accepted the current element
- pe_result  in  DATA_W  PE combinational accumulate output

Behaviour:
- Reset:
  - FSM returns to IDLE.
  - busy, done, mem_en, pe_active and pe_vec_fin are 0.
  - dot_result, left_addr, right_addr and the element counters are 0.
  - Reset mid-operation aborts immediately; there is no done pulse.
- FSM states: IDLE, FETCH, STREAM, FINISH.
- IDLE:
  - start with length != 0: latch length and bases; addresses ← bases; go to FETCH.
  - start with length == 0: dot_result ← 0; done=1 next cycle; stay IDLE.
  - start while not in IDLE is ignored.
- FETCH (1 cycle):
  - mem_en=1; addresses advance by 1 after issue; go to STREAM.
- STREAM:
  - pe_active=1; pe_left/pe_right are the registered read data.
  - Advance condition is pe_step_fin=1. On advance: issue count +1; if issue count < length, mem_en=1 and the next address is presented.
  - pe_step_fin=0 stalls: mem_en=0, addresses and counters hold, and the memories hold their read data, so operands stay stable.
  - pe_vec_fin=1 while the accepted-element count == length-1.
  - On the advance cycle with pe_vec_fin=1: dot_result ← pe_result; go to FINISH.
- FINISH: done=1 for one cycle; pe_active=0; go to IDLE.
- busy=1 in FETCH, STREAM and FINISH.
- Latency with no stalls: done asserts length+2 cycles after the start cycle; each stall cycle adds 1.
- Arithmetic:
  - Addresses increment modulo 2^ADDR_W; wrap is legal.
  - Counters are 32-bit unsigned; length up to 2^32-1 is supported.

Optional Feature:
- Macro STRIDE_EN.
- When defined: adds inputs left_stride and right_stride (ADDR_W each), latched on start. Addresses advance by the latched stride, modulo 2^ADDR_W. Stride 0 re-reads one element.
- When undefined: no stride ports; stride is fixed at 1.

Decomposition:
- Shared package pe_pkg holds:
  - DATA_W and ADDR_W defaults;
  - the FSM state enum seq_state_t (IDLE, FETCH, STREAM, FINISH);
  - the 32-bit length typedef vec_len_t.
- One natural sub-module: vec_addr_gen, which holds the base/stride latch plus the increment-with-wrap address register. It is instantiated twice (left and right).

Test Plan:
- length=3, bases 0/8, left mem [1,2,3], right mem [4,5,6], PE model accumulates, pe_step_fin=1 → pe_active for 3 cycles, pe_vec_fin only on the 3rd, dot_result=32, done at cycle start+5.
- Same vectors with pe_step_fin=0 on the 2nd element for 2 cycles → operands held stable, addresses frozen, dot_result=32, done 2 cycles later.
- length=0 start → done the next cycle, dot_result=0, mem_en never asserted, busy stays 0.
- left_base=1022, length=4 (ADDR_W=10) → left_addr sequence 1022, 1023, 0, 1.
- rst asserted in STREAM after 1 element → next cycle all outputs 0, state IDLE, no done. A following start with length=2 completes correctly.
- STRIDE_EN defined, stride 2, base 0, length 3 → left_addr 0, 2, 4. Undefined build → left_addr 0, 1, 2.
